// File: rtl/rv_mem_responder.sv
// rv_mem responder: single-port synchronous RAM behind a valid/ready request port,
// with read data returned in order through a small response FIFO.
module rv_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q  [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic          pending_q, pending_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic          rd_fire_s, wr_fire_s, push_s, pop_s;
  logic [CW:0]   occ_s;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    inc_ptr = (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Handshake decode, occupancy and next-state for the response path.
  always_comb begin
    occ_s      = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
    req_ready  = rst && (occ_s < DEPTH_C);
    resp_valid = (count_q != {CW{1'b0}});
    rd_fire_s  = req_valid && req_ready && req_op;
    wr_fire_s  = req_valid && req_ready && !req_op;
    push_s     = pending_q;
    pop_s      = resp_valid && resp_ready;
    pending_d  = rd_fire_s;
    wr_ptr_d   = push_s ? inc_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop_s ? inc_ptr(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (resp_valid) begin
      resp_data = fifo_q[rd_ptr_q];
    end else begin
      resp_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Control state; RAM and FIFO storage deliberately carry no reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 1'b0;
      count_q   <= {CW{1'b0}};
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Synchronous RAM: write-through to the array, registered read port.
  always_ff @(posedge clk) begin
    if (wr_fire_s) mem_q[req_addr] <= req_data;
    if (rd_fire_s) rd_data_q <= mem_q[req_addr];
  end

  // Response FIFO storage, filled from the RAM read stage.
  always_ff @(posedge clk) begin
    if (push_s) fifo_q[wr_ptr_q] <= rd_data_q;
  end

endmodule

// File: tb/tb_rv_mem_responder.sv
// Randomised scoreboard bench for rv_mem_responder (depth-4 and depth-3 instances).
module tb_rv_mem_responder;
  localparam int DW = 32, AW = 10, DEPTH = 4, AW3 = 6, DEPTH3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic req_valid, req_ready, req_op, resp_valid, resp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data, resp_data;
  logic req_valid3, req_ready3, req_op3, resp_valid3, resp_ready3;
  logic [AW3-1:0] req_addr3;
  logic [DW-1:0] req_data3, resp_data3;

  rv_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data));

  rv_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW3), .RESP_DEPTH(DEPTH3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
    .req_addr(req_addr3), .req_data(req_data3), .resp_valid(resp_valid3),
    .resp_ready(resp_ready3), .resp_data(resp_data3));

  int n_cmp = 0, n_fail = 0, cyc = 0, stalls = 0, pops3 = 0;
  logic [DW-1:0] mdl  [0:(1<<AW)-1];
  logic [DW-1:0] mdl3 [0:(1<<AW3)-1];
  logic [DW-1:0] exp_q[$], exp3_q[$];
  int pop_cyc[$];
  bit hold_prev = 1'b0, hold_prev3 = 1'b0, rnd_rr = 1'b0, alt_rr3 = 1'b0;
  logic [DW-1:0] hold_data, hold_data3;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard for the depth-4 instance.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    cyc++;
    if (!rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stable_valid", resp_valid, 1);
        chk("stable_data", resp_data, hold_data);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_resp", resp_data, 32'hxxxx_xxxx);
        else begin
          e = exp_q.pop_front();
          chk("resp_data", resp_data, e);
          pop_cyc.push_back(cyc);
        end
      end else if (!resp_valid) begin
        chk("idle_data_zero", resp_data, 0);
      end
      if (req_valid && req_ready) begin
        if (req_op) exp_q.push_back(mdl[req_addr]);
        else mdl[req_addr] = req_data;
        chk("outstanding_le_depth", 32'(exp_q.size() <= DEPTH), 1);
      end
      hold_prev = resp_valid && !resp_ready;
      hold_data = resp_data;
    end
  end

  // Monitor/scoreboard for the depth-3 instance.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst) begin
      exp3_q.delete();
      hold_prev3 = 1'b0;
    end else begin
      if (hold_prev3) chk("d3_stable_data", resp_data3, hold_data3);
      if (resp_valid3 && resp_ready3) begin
        if (exp3_q.size() == 0) chk("d3_unexpected_resp", resp_data3, 32'hxxxx_xxxx);
        else begin
          e = exp3_q.pop_front();
          chk("d3_resp_data", resp_data3, e);
          pops3++;
        end
      end else if (!resp_valid3) begin
        chk("d3_idle_data_zero", resp_data3, 0);
      end
      if (req_valid3 && req_ready3) begin
        if (req_op3) exp3_q.push_back(mdl3[req_addr3]);
        else mdl3[req_addr3] = req_data3;
        chk("d3_outstanding_le_depth", 32'(exp3_q.size() <= DEPTH3), 1);
      end
      hold_prev3 = resp_valid3 && !resp_ready3;
      hold_data3 = resp_data3;
    end
  end

  task automatic issue(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int max_cyc, output bit ok);
    bit acc;
    ok = 1'b0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (rnd_rr) resp_ready = 1'($urandom_range(0, 1));
      if (acc) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    req_valid = 1'b0;
  endtask

  task automatic must_issue(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    issue(op, a, d, 100, ok);
    if (!ok) chk("req_accept_timeout", 32'(ok), 1);
  endtask

  task automatic must_issue3(input logic op, input logic [AW3-1:0] a, input logic [DW-1:0] d);
    bit acc, ok;
    ok = 1'b0;
    req_valid3 = 1'b1; req_op3 = op; req_addr3 = a; req_data3 = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      acc = req_ready3;
      @(posedge clk);
      #1;
      if (alt_rr3) resp_ready3 = ~resp_ready3;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid3 = 1'b0;
    if (!ok) chk("d3_req_accept_timeout", 32'(ok), 1);
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int acc_n;
    rst = 1'b0;
    req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_data = '0; resp_ready = 1'b0;
    req_valid3 = 1'b0; req_op3 = 1'b0; req_addr3 = '0; req_data3 = '0; resp_ready3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_resp_valid", resp_valid, 0);
    @(posedge clk);
    #1;

    // Write then immediate read of the same word; check 2-cycle latency.
    resp_ready = 1'b1;
    must_issue(1'b0, 10'h005, 32'hDEADBEEF);
    must_issue(1'b1, 10'h005, 32'h0);
    @(negedge clk);
    chk("t1_valid_pending_cycle", resp_valid, 0);
    @(negedge clk);
    chk("t1_valid_latency2", resp_valid, 1);
    chk("t1_data", resp_data, 32'hDEADBEEF);
    drain();

    // Full-rate back-to-back reads.
    for (int i = 0; i < 16; i++) must_issue(1'b0, AW'(i), DW'(i * 3));
    pop_cyc.delete();
    stalls = 0;
    for (int i = 0; i < 16; i++) must_issue(1'b1, AW'(i), 32'h0);
    drain();
    chk("t2_stalls", stalls, 0);
    chk("t2_npops", pop_cyc.size(), 16);
    if (pop_cyc.size() == 16) chk("t2_consecutive", pop_cyc[15] - pop_cyc[0], 15);

    // Backpressure: only DEPTH reads fit while responses are blocked.
    resp_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, AW'(i), 32'h0, 4, ok);
      if (ok) acc_n++;
    end
    chk("t3_accepted", acc_n, 4);
    @(negedge clk);
    chk("t3_ready_low", req_ready, 0);
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    must_issue(1'b1, 10'd4, 32'h0);
    must_issue(1'b1, 10'd5, 32'h0);
    drain();

    // Random read/write mix with random response backpressure.
    rnd_rr = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        resp_ready = 1'($urandom_range(0, 1));
      end
      must_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
    end
    rnd_rr = 1'b0;
    drain();

    // Reset with three responses queued.
    resp_ready = 1'b0;
    for (int i = 1; i < 4; i++) must_issue(1'b1, AW'(i), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_fifo_holding", resp_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_rst_resp_valid", resp_valid, 0);
    chk("t5_rst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_release_req_ready", req_ready, 1);
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_no_stale", resp_valid, 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) must_issue(1'b1, AW'(i), 32'h0);
    drain();

    // Depth-3 instance: pointer wrap with alternating response ready.
    for (int i = 0; i < 50; i++) must_issue3(1'b0, AW3'(i), $urandom);
    alt_rr3 = 1'b1;
    pops3 = 0;
    for (int i = 0; i < 50; i++) must_issue3(1'b1, AW3'(i), 32'h0);
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      #1;
      resp_ready3 = ~resp_ready3;
      if (exp3_q.size() == 0) break;
    end
    alt_rr3 = 1'b0;
    chk("t6_pops", pops3, 50);
    chk("t6_drain_empty", exp3_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1);
  end

endmodule

// File: doc/rv_mem_responder.md
Name: rv_mem_responder

Overview:
- Responder end of the rv_mem request channel: accepts read/write requests on the valid/ready request port and stores data in an internal synchronous RAM of 2**ADDR_WIDTH words.
- Returns read data on a separate valid/ready response stream, in request order.
- Sits behind any rv_mem initiator (fetch, load/store unit, testbench driver) as the backing memory or as the template for memory-mapped peripherals.

Parameters:
DATA_WIDTH, 32, word width of request data and response data
ADDR_WIDTH, 10, word address width; RAM depth is 2**ADDR_WIDTH
RESP_DEPTH, 4, entries in the response FIFO; legal range 2..16

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  1  request valid
req_ready  out  1  request ready
req_op  in  1  rv_memory_op: 1 = RV_MEM_READ, 0 = RV_MEM_WRITE
req_addr  in  ADDR_WIDTH  word address
req_data  in  DATA_WIDTH  write data; ignored for reads
resp_valid  out  1  read response valid
resp_ready  in  1  read response ready
resp_data  out  DATA_WIDTH  read data

Behaviour:
- Reset (rst=0, async): response FIFO emptied (count=0, pointers=0); read-pending flag cleared; resp_valid=0; req_ready=0 while rst=0. RAM contents are not reset.
- Request handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1. At most one request per cycle. req_ready gates both reads and writes.
- req_ready = (count + pending) < RESP_DEPTH.
  - count = FIFO occupancy; pending = 1 while a read sits in the RAM stage.
  - Both terms are registered, so there is no combinational path from resp_ready or req_valid to req_ready.
  - req_ready = 1 on the first cycle after reset release.
- Write accepted at edge T: RAM[req_addr] <= req_data at edge T. No response is generated.
- Read accepted at edge T:
  - RAM is read synchronously; pending=1 during cycle T+1.
  - The read word is pushed into the FIFO at edge T+1.
  - resp_valid is asserted no earlier than cycle T+2 (one extra cycle through the FIFO). Minimum read latency from acceptance to resp_valid is 2 cycles.
- Read-after-write: a read accepted at the edge after a write to the same address returns the new data. Ordering is by acceptance order, since only one request is accepted per edge.
- Response handshake:
  - resp_valid = (count > 0); resp_data = FIFO head.
  - resp_data = 0 when count = 0.
  - Pop on edges where resp_valid=1 and resp_ready=1.
  - Once asserted, resp_valid and resp_data stay stable until popped.
- Simultaneous push and pop: count unchanged; both pointers advance. Pointers wrap modulo RESP_DEPTH; non-power-of-two depths must wrap correctly.
- Full-rate operation: with resp_ready held at 1, back-to-back reads sustain 1 read/cycle and req_ready never drops (count ≤ 1, pending ≤ 1).
- Backpressure:
  - With resp_ready=0, at most RESP_DEPTH reads are outstanding (FIFO plus RAM stage); req_ready then deasserts.
  - Writes are also stalled while req_ready=0.
  - The FIFO never overflows, and no response is dropped or duplicated.
- Reset mid-operation: all outstanding reads are discarded with no response after release. RAM writes completed before reset persist.

Test Plan:
- Reset release, then write 0xDEADBEEF to addr 0x005 and immediately read 0x005 -> resp_valid at 2 cycles after read acceptance with resp_data=0xDEADBEEF; no response for the write.
- Write addr i ← i*3 for i=0..15, then 16 back-to-back reads with resp_ready=1 -> req_ready stays 1 throughout; responses 0,3,6..45 in order on 16 consecutive cycles.
- resp_ready=0, issue 6 reads -> exactly 4 accepted, req_ready=0 from then on; raise resp_ready -> 4 responses in order, then remaining 2 accepted and returned; count never exceeds 4.
- Random resp_ready (50%) with a random read/write mix over 2000 requests against a reference model -> every read matches the model; resp_data stable while resp_valid=1 and resp_ready=0.
- Fill FIFO with 3 responses, assert rst=0 for one cycle mid-stream -> resp_valid=0 and req_ready=0 immediately; after release req_ready=1, no stale responses appear, and earlier writes read back correctly.
- RESP_DEPTH=3 build, 50 reads with alternating resp_ready -> correct pointer wrap, all 50 responses in order.
